oled_text_renderer: RTL and testbench

- Sequences the 8x8 font glyph lookup and streams a short text string as RGB565 pixel writes to the OLED RGB panel pixel sink (frame buffer or panel driver).
- Accepts one string request at a time: NUM_CHARS ASCII codes plus a character-cell position.
- Fetches each glyph row from the external font ROM and emits pixels in raster order over a valid/ready handshake.
- Reports completion, bad characters and out-of-range placement.

---
 rtl/oled_text_renderer.sv | 186 ++++++++++++++++++
 tb/tb_oled_text_renderer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_text_renderer.sv
`default_nettype none
// ============================================================================
// Module      : oled_text_renderer
// Description : Renders a short ASCII string through an external 8x8 font ROM
//               and streams it to an RGB565 pixel sink in strict raster order.
// Revision    : 1.0 - initial release
// ============================================================================
module oled_text_renderer #(
    parameter int          NUM_CHARS = 3,
    parameter logic [15:0] COLOR_FG  = 16'hFFFF,
    parameter logic [15:0] COLOR_BG  = 16'h0000,
    parameter int          SCREEN_W  = 96,
    parameter int          SCREEN_H  = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [8*NUM_CHARS-1:0] req_chars,
    input  logic [3:0]             req_col,
    input  logic [2:0]             req_row,
    input  logic                   abort,
    output logic [10:0]            rom_addr,
    input  logic [7:0]             rom_data,
    input  logic                   rom_hit,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [6:0]             pix_x,
    output logic [5:0]             pix_y,
    output logic [15:0]            pix_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err_badchar,
    output logic                   err_range
);

    localparam int C_CW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam logic [C_CW-1:0] C_C_LAST = C_CW'(NUM_CHARS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_req_ready;
    logic [8*NUM_CHARS-1:0]   r_chars;
    logic [3:0]               r_col;
    logic [2:0]               r_row;
    logic [2:0]               r_p;
    logic [2:0]               r_r;
    logic [C_CW-1:0]          r_c;
    logic [7:0]               r_glyph;
    logic [10:0]              r_rom_addr;
    logic                     r_err_badchar;
    logic                     r_err_range;

    logic                     w_accept;
    logic                     w_pix_fire;
    logic                     w_range_bad;
    logic [31:0]              w_col_px_end;
    logic [31:0]              w_row_px_end;
    logic [C_CW-1:0]          w_adv_c;
    logic [2:0]               w_adv_r;
    logic [7:0]               w_adv_char;
    logic [3:0]               w_cell_x;
    logic                     w_emit;

    // Placement check is done on the raw request so a bad request never touches the ROM.
    assign w_col_px_end = ({28'd0, req_col} + 32'(NUM_CHARS)) << 3;
    assign w_row_px_end = ({29'd0, req_row} + 32'd1) << 3;
    assign w_range_bad  = (w_col_px_end > 32'(SCREEN_W)) || (w_row_px_end > 32'(SCREEN_H));

    // Next glyph position: walk across the characters, then drop to the next glyph row.
    assign w_adv_c    = (r_c == C_C_LAST) ? '0 : r_c + 1'b1;
    assign w_adv_r    = (r_c == C_C_LAST) ? r_r + 3'd1 : r_r;
    assign w_adv_char = r_chars[{w_adv_c, 3'b000} +: 8];

    // Next-state decode; abort wins over any pixel handshake in the same cycle.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_pix_fire = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept = 1'b1;
                    w_next   = w_range_bad ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: w_next = abort ? S_IDLE : S_WAIT;
            S_WAIT:  w_next = abort ? S_IDLE : S_EMIT;
            S_EMIT: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (pix_ready) begin
                    w_pix_fire = 1'b1;
                    if (r_p == 3'd7) begin
                        w_next = ((r_c == C_C_LAST) && (r_r == 3'd7)) ? S_DONE : S_FETCH;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register; req_ready is registered so it stays low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= (w_next == S_IDLE);
        end
    end

    // Request latch, glyph counters, ROM address and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chars       <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_p           <= '0;
            r_r           <= '0;
            r_c           <= '0;
            r_glyph       <= '0;
            r_rom_addr    <= '0;
            r_err_badchar <= 1'b0;
            r_err_range   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_chars       <= req_chars;
                r_col         <= req_col;
                r_row         <= req_row;
                r_p           <= '0;
                r_r           <= '0;
                r_c           <= '0;
                r_err_badchar <= 1'b0;
                r_err_range   <= w_range_bad;
                if (!w_range_bad) begin
                    r_rom_addr <= {req_chars[7:0], 3'd0};
                end
            end
            if ((r_state == S_WAIT) && (w_next == S_EMIT)) begin
                r_glyph <= rom_hit ? rom_data : 8'h00;
                r_p     <= '0;
                if (!rom_hit) begin
                    r_err_badchar <= 1'b1;
                end
            end
            if (w_pix_fire) begin
                r_p <= r_p + 3'd1;
                if ((r_p == 3'd7) && (w_next == S_FETCH)) begin
                    r_c        <= w_adv_c;
                    r_r        <= w_adv_r;
                    r_rom_addr <= {w_adv_char, w_adv_r};
                end
            end
        end
    end

    // Pixel fields are forced to zero outside EMIT so idle outputs read as 0.
    always_comb begin
        w_emit   = (r_state == S_EMIT);
        w_cell_x = r_col + 4'(r_c);
        pix_x    = w_emit ? {w_cell_x, r_p} : 7'd0;
        pix_y    = w_emit ? {r_row, r_r} : 6'd0;
        pix_data = w_emit ? (r_glyph[r_p] ? COLOR_FG : COLOR_BG) : 16'h0000;
    end

    assign pix_valid   = w_emit;
    assign req_ready   = r_req_ready;
    assign rom_addr    = r_rom_addr;
    assign busy        = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_EMIT);
    assign done        = (r_state == S_DONE);
    assign err_badchar = r_err_badchar;
    assign err_range   = r_err_range;

endmodule
`default_nettype wire

// File: tb/tb_oled_text_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_oled_text_renderer
// Description : Self-checking bench for oled_text_renderer with a font ROM
//               model and a raster-order reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_text_renderer;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [8*N-1:0] req_chars;
    logic [3:0]    req_col;
    logic [2:0]    req_row;
    logic          abort;
    logic [10:0]   rom_addr;
    logic [7:0]    rom_data;
    logic          rom_hit;
    logic          pix_valid;
    logic          pix_ready;
    logic [6:0]    pix_x;
    logic [5:0]    pix_y;
    logic [15:0]   pix_data;
    logic          busy;
    logic          done;
    logic          err_badchar;
    logic          err_range;

    oled_text_renderer #(
        .NUM_CHARS (N),
        .COLOR_FG  (16'hFFFF),
        .COLOR_BG  (16'h0000),
        .SCREEN_W  (96),
        .SCREEN_H  (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_chars   (req_chars),
        .req_col     (req_col),
        .req_row     (req_row),
        .abort       (abort),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rom_hit     (rom_hit),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_data    (pix_data),
        .busy        (busy),
        .done        (done),
        .err_badchar (err_badchar),
        .err_range   (err_range)
    );

    always #5 clk = ~clk;

    logic [45:0] all_out;
    assign all_out = {req_ready, rom_addr, pix_valid, pix_x, pix_y, pix_data,
                      busy, done, err_badchar, err_range};

    int tests_run    = 0;
    int tests_failed = 0;

    // Font model: arbitrary but fixed glyph bits, blank bottom row, 'G' row 0 = 3C.
    function automatic logic [7:0] font_row(input logic [7:0] a, input logic [2:0] r);
        logic [15:0] h;
        if (r == 3'd7) return 8'h00;
        if (a == 8'h47 && r == 3'd0) return 8'h3C;
        h = {8'h00, a} * 16'd29 + {13'd0, r} * 16'd113 + 16'h005A;
        return h[7:0] ^ h[12:5];
    endfunction

    function automatic bit supported(input logic [7:0] a);
        return (a >= 8'h20) && (a <= 8'h7E);
    endfunction

    // ROM answers one cycle after the address.
    always @(posedge clk) begin
        rom_data <= font_row(rom_addr[10:3], rom_addr[2:0]);
        rom_hit  <= supported(rom_addr[10:3]);
    end

    logic [28:0] got_q[$];
    logic [28:0] exp_q[$];
    bit exp_bad, exp_oor;

    int   d_done_cyc, d_done_cnt, d_valid_cyc, d_stab_err, d_first_valid;
    int   d_first_addr, d_addr_chg, d_badchar_first, d_abort_cyc;
    logic d_err_b, d_err_r, d_ready_after_done;
    logic d_post_valid, d_post_busy, d_post_ready, d_post_badchar;

    // Reference: every glyph row of every character, row-major across the string.
    task automatic build_exp(input logic [8*N-1:0] chars, input logic [3:0] col,
                             input logic [2:0] row);
        logic [7:0] ch;
        logic [7:0] bits;
        int x, y;
        exp_q.delete();
        exp_bad = 0;
        exp_oor = (8 * (int'(col) + N) > 96) || (8 * int'(row) + 8 > 64);
        if (exp_oor) return;
        for (int k = 0; k < N; k++) if (!supported(chars[8*k +: 8])) exp_bad = 1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < N; c++)
                for (int p = 0; p < 8; p++) begin
                    ch   = chars[8*c +: 8];
                    bits = supported(ch) ? font_row(ch, 3'(r)) : 8'h00;
                    x    = 8 * (int'(col) + c) + p;
                    y    = 8 * int'(row) + r;
                    exp_q.push_back({7'(x), 6'(y), bits[p] ? 16'hFFFF : 16'h0000});
                end
    endtask

    function automatic int first_diff();
        if (got_q.size() != exp_q.size()) return -2;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // Issues one request and records what the DUT does, cycle by cycle after acceptance.
    task automatic drive_req(input logic [8*N-1:0] chars, input logic [3:0] col,
                             input logic [2:0] row, input bit bp, input int abort_at,
                             input int budget);
        int cyc;
        bit stall;
        logic [28:0] held;
        logic [10:0] addr0, prev_addr;
        got_q.delete();
        d_done_cyc = -1; d_done_cnt = 0; d_valid_cyc = 0; d_stab_err = 0;
        d_first_valid = -1; d_first_addr = -1; d_addr_chg = 0; d_badchar_first = -1;
        d_abort_cyc = -1; d_err_b = 1'bx; d_err_r = 1'bx; d_ready_after_done = 1'bx;
        d_post_valid = 1'bx; d_post_busy = 1'bx; d_post_ready = 1'bx; d_post_badchar = 1'bx;
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        if (req_ready !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL req_ready_wait: req_ready=%b required 1", req_ready);
            return;
        end
        addr0 = rom_addr; prev_addr = rom_addr;
        req_chars = chars; req_col = col; req_row = row; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_chars = 24'($urandom); req_col = 4'($urandom); req_row = 3'($urandom);
        cyc = 1; stall = 0; held = '0;
        while (cyc <= budget) begin
            if (done === 1'b1) begin
                d_done_cnt++;
                if (d_done_cyc < 0) begin d_done_cyc = cyc; d_err_b = err_badchar; d_err_r = err_range; end
            end
            if (d_done_cyc >= 0 && cyc == d_done_cyc + 1) d_ready_after_done = req_ready;
            if (d_abort_cyc >= 0 && cyc == d_abort_cyc + 1) begin
                d_post_valid = pix_valid; d_post_busy = busy;
                d_post_ready = req_ready; d_post_badchar = err_badchar;
            end
            if (rom_addr !== addr0 && d_first_addr < 0) d_first_addr = cyc;
            if (rom_addr !== prev_addr) d_addr_chg++;
            prev_addr = rom_addr;
            if (err_badchar === 1'b1 && d_badchar_first < 0) d_badchar_first = cyc;
            if (pix_valid === 1'b1) begin
                d_valid_cyc++;
                if (d_first_valid < 0) d_first_valid = cyc;
            end
            if (stall && (pix_valid !== 1'b1 || {pix_x, pix_y, pix_data} !== held)) d_stab_err++;
            abort = 1'b0;
            pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (abort_at >= 0 && d_abort_cyc < 0 && pix_valid === 1'b1 && got_q.size() == abort_at) begin
                abort = 1'b1; pix_ready = 1'b0; d_abort_cyc = cyc;
            end
            stall = (pix_valid === 1'b1) && !pix_ready && !abort;
            held  = {pix_x, pix_y, pix_data};
            if (pix_valid === 1'b1 && pix_ready) got_q.push_back(held);
            if (d_done_cyc >= 0 && cyc >= d_done_cyc + 1) break;
            if (d_abort_cyc >= 0 && cyc >= d_abort_cyc + 4) break;
            @(posedge clk); #1; cyc++;
        end
        abort = 1'b0; pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (all_out !== 46'd0) begin
            tests_failed++; $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        repeat (2) @(posedge clk);
        #3; rst_n = 1'b1;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ready_before_edge: got %b required 0", req_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready_after_edge: got %b required 1", req_ready);
        end
    endtask

    task automatic test_basic();
        int idx;
        build_exp({8'h20, 8'h4F, 8'h47}, 4'd0, 3'd0);
        drive_req({8'h20, 8'h4F, 8'h47}, 4'd0, 3'd0, 0, -1, 2000);
        idx = first_diff();
        tests_run++;
        if (idx != -1 || got_q.size() != 192) begin
            tests_failed++; $display("FAIL basic_seq: diff_at=%0d got_n=%0d required_n=192", idx, got_q.size());
        end
        tests_run++;
        if (got_q.size() < 3 || got_q[0] !== {7'd0, 6'd0, 16'h0000} || got_q[2] !== {7'd2, 6'd0, 16'hFFFF}) begin
            tests_failed++; $display("FAIL basic_first_pixels: got_n=%0d (pixel0 BG, pixel2 FG required)", got_q.size());
        end
        tests_run++;
        if (d_done_cyc != 241 || d_done_cnt != 1) begin
            tests_failed++; $display("FAIL basic_done_cycle: got %0d (count %0d) required 241 (count 1)", d_done_cyc, d_done_cnt);
        end
        tests_run++;
        if (d_first_addr != 1 || d_first_valid != 3) begin
            tests_failed++; $display("FAIL basic_latency: rom_addr at %0d pix_valid at %0d required 1 and 3", d_first_addr, d_first_valid);
        end
        tests_run++;
        if (d_err_b !== 1'b0 || d_err_r !== 1'b0 || d_ready_after_done !== 1'b1) begin
            tests_failed++; $display("FAIL basic_flags: badchar=%b range=%b ready_after=%b required 0 0 1", d_err_b, d_err_r, d_ready_after_done);
        end
    endtask

    task automatic test_offset();
        int idx;
        build_exp({8'h53, 8'h52, 8'h45}, 4'd9, 3'd7);
        drive_req({8'h53, 8'h52, 8'h45}, 4'd9, 3'd7, 0, -1, 2000);
        idx = first_diff();
        tests_run++;
        if (idx != -1) begin
            tests_failed++; $display("FAIL offset_seq: diff_at=%0d got_n=%0d required_n=%0d", idx, got_q.size(), exp_q.size());
        end
        tests_run++;
        if (got_q.size() == 0 || got_q[0][28:16] !== {7'd72, 6'd56} || got_q[got_q.size()-1] !== {7'd95, 6'd63, 16'h0000}) begin
            tests_failed++; $display("FAIL offset_corners: got_n=%0d first/last not (72,56)/(95,63,BG)", got_q.size());
        end
        tests_run++;
        if (d_err_b !== 1'b0 || d_err_r !== 1'b0 || d_done_cyc != 241) begin
            tests_failed++; $display("FAIL offset_flags: badchar=%b range=%b done=%0d required 0 0 241", d_err_b, d_err_r, d_done_cyc);
        end
    endtask

    task automatic test_range();
        drive_req({8'h43, 8'h42, 8'h41}, 4'd10, 3'd0, 0, -1, 50);
        tests_run++;
        if (d_done_cyc != 1 || d_done_cnt != 1 || d_err_r !== 1'b1 || d_err_b !== 1'b0) begin
            tests_failed++; $display("FAIL range_done: done=%0d cnt=%0d range=%b badchar=%b required 1 1 1 0", d_done_cyc, d_done_cnt, d_err_r, d_err_b);
        end
        tests_run++;
        if (d_valid_cyc != 0 || d_addr_chg != 0) begin
            tests_failed++; $display("FAIL range_quiet: valid_cycles=%0d addr_changes=%0d required 0 0", d_valid_cyc, d_addr_chg);
        end
    endtask

    task automatic test_backpressure();
        int idx;
        build_exp({8'h20, 8'h4F, 8'h47}, 4'd0, 3'd0);
        drive_req({8'h20, 8'h4F, 8'h47}, 4'd0, 3'd0, 1, -1, 2000);
        idx = first_diff();
        tests_run++;
        if (idx != -1 || got_q.size() != 192) begin
            tests_failed++; $display("FAIL bp_seq: diff_at=%0d got_n=%0d required_n=192", idx, got_q.size());
        end
        tests_run++;
        if (d_stab_err != 0 || d_done_cnt != 1) begin
            tests_failed++; $display("FAIL bp_stability: unstable_cycles=%0d done_count=%0d required 0 1", d_stab_err, d_done_cnt);
        end
    endtask

    task automatic test_badchar();
        int idx, fg1;
        build_exp({8'h42, 8'h81, 8'h41}, 4'd0, 3'd0);
        drive_req({8'h42, 8'h81, 8'h41}, 4'd0, 3'd0, 0, -1, 2000);
        idx = first_diff();
        fg1 = 0;
        foreach (got_q[i]) if (got_q[i][28:22] >= 7'd8 && got_q[i][28:22] < 7'd16 && got_q[i][15:0] !== 16'h0000) fg1++;
        tests_run++;
        if (idx != -1 || fg1 != 0) begin
            tests_failed++; $display("FAIL badchar_seq: diff_at=%0d char1_non_bg=%0d required -1 0", idx, fg1);
        end
        tests_run++;
        if (d_badchar_first != 13 || d_err_b !== 1'b1 || err_badchar !== 1'b1) begin
            tests_failed++; $display("FAIL badchar_flag: first_set=%0d at_done=%b after=%b required 13 1 1", d_badchar_first, d_err_b, err_badchar);
        end
        drive_req({8'h20, 8'h4F, 8'h47}, 4'd0, 3'd0, 0, -1, 2000);
        tests_run++;
        if (d_badchar_first != -1 || d_err_b !== 1'b0) begin
            tests_failed++; $display("FAIL badchar_clear: first_set=%0d at_done=%b required -1 0", d_badchar_first, d_err_b);
        end
    endtask

    task automatic test_abort();
        int idx;
        drive_req({8'h42, 8'h81, 8'h41}, 4'd1, 3'd2, 0, 49, 2000);
        tests_run++;
        if (d_abort_cyc < 0 || d_post_valid !== 1'b0 || d_post_busy !== 1'b0 || d_post_ready !== 1'b1) begin
            tests_failed++; $display("FAIL abort_post: abort_cyc=%0d valid=%b busy=%b ready=%b required 0 0 1", d_abort_cyc, d_post_valid, d_post_busy, d_post_ready);
        end
        tests_run++;
        if (d_done_cnt != 0 || got_q.size() != 49 || d_post_badchar !== 1'b1) begin
            tests_failed++; $display("FAIL abort_effects: done_count=%0d pixels=%0d badchar=%b required 0 49 1", d_done_cnt, got_q.size(), d_post_badchar);
        end
        build_exp({8'h4B, 8'h4A, 8'h49}, 4'd3, 3'd4);
        drive_req({8'h4B, 8'h4A, 8'h49}, 4'd3, 3'd4, 0, -1, 2000);
        idx = first_diff();
        tests_run++;
        if (idx != -1 || d_done_cyc != 241) begin
            tests_failed++; $display("FAIL abort_recover: diff_at=%0d done=%0d required -1 241", idx, d_done_cyc);
        end
    endtask

    task automatic test_rst_pulse();
        int idx;
        int cyc;
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        req_chars = {8'h42, 8'h81, 8'h41}; req_col = 4'd2; req_row = 3'd1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (60) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (all_out !== 46'd0) begin
            tests_failed++; $display("FAIL rst_async_outputs: got %h required 0", all_out);
        end
        #2; rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (req_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL rst_recover_state: ready=%b done=%b busy=%b required 1 0 0", req_ready, done, busy);
        end
        build_exp({8'h20, 8'h4F, 8'h47}, 4'd5, 3'd3);
        drive_req({8'h20, 8'h4F, 8'h47}, 4'd5, 3'd3, 0, -1, 2000);
        idx = first_diff();
        tests_run++;
        if (idx != -1 || d_done_cyc != 241 || d_err_b !== 1'b0) begin
            tests_failed++; $display("FAIL rst_new_request: diff_at=%0d done=%0d badchar=%b required -1 241 0", idx, d_done_cyc, d_err_b);
        end
    endtask

    task automatic test_random();
        logic [8*N-1:0] chars;
        logic [3:0] col;
        logic [2:0] row;
        bit bp;
        int idx;
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < N; k++)
                chars[8*k +: 8] = ($urandom_range(0, 7) == 0) ? (8'h80 | 8'($urandom_range(0, 127)))
                                                              : 8'($urandom_range(32, 126));
            col = 4'($urandom_range(0, 11));
            row = 3'($urandom_range(0, 7));
            bp  = 1'($urandom_range(0, 1));
            build_exp(chars, col, row);
            drive_req(chars, col, row, bp, -1, 2000);
            idx = first_diff();
            tests_run++;
            if (idx != -1 || d_stab_err != 0 || d_done_cnt != 1) begin
                tests_failed++; $display("FAIL random_seq[%0d]: diff_at=%0d unstable=%0d done_count=%0d required -1 0 1", t, idx, d_stab_err, d_done_cnt);
            end
            tests_run++;
            if (d_err_b !== exp_bad || d_err_r !== exp_oor ||
                (exp_oor && d_done_cyc != 1) || (!exp_oor && !bp && d_done_cyc != 241)) begin
                tests_failed++; $display("FAIL random_flags[%0d]: badchar=%b range=%b done=%0d required %b %b", t, d_err_b, d_err_r, d_done_cyc, exp_bad, exp_oor);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_chars = '0; req_col = '0; req_row = '0;
        abort = 1'b0; pix_ready = 1'b1;
        test_reset();
        test_basic();
        test_offset();
        test_range();
        test_backpressure();
        test_badchar();
        test_abort();
        test_rst_pulse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
